// File: rtl/inst_rom_loader_if.sv
// rtl/inst_rom_loader_if.sv - programming and fetch bus of the instruction ROM loader
interface inst_rom_loader_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              prog_valid_i;
    logic              prog_ready_o;
    logic [DATA_W-1:0] prog_data_i;
    logic              prog_last_i;
    logic              rom_ce_i;
    logic [ADDR_W-1:0] rom_addr_i;
    logic [DATA_W-1:0] rom_data_o;

    modport master (
        output prog_valid_i, prog_data_i, prog_last_i, rom_ce_i, rom_addr_i,
        input  prog_ready_o, rom_data_o
    );

    modport slave (
        input  prog_valid_i, prog_data_i, prog_last_i, rom_ce_i, rom_addr_i,
        output prog_ready_o, rom_data_o
    );
endinterface

// File: rtl/inst_rom_loader.sv
// rtl/inst_rom_loader.sv - loadable instruction store holding the CPU in reset during load
// Optional running checksum of loaded words: INST_ROM_LOADER_CSUM_EN
module inst_rom_loader #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    inst_rom_loader_if.slave        bus,
    output logic                    cpu_rst_o,
    output logic [$clog2(DEPTH):0]  load_cnt_o,
    output logic                    ovf_o,
    output logic [DATA_W-1:0]       csum_o
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam int CMP_W = (ADDR_W > CNT_W) ? ADDR_W : CNT_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              ready_q, ready_d;
    logic              ovf_q, ovf_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              xfer;
    logic              hit;

    assign xfer = ready_q & bus.prog_valid_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_LOAD: begin
                if (xfer) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (bus.prog_last_i) begin
                        state_d = ST_RUN;
                    end else if (cnt_q == CNT_W'(DEPTH - 1)) begin
                        state_d = ST_RUN;
                        ovf_d   = 1'b1;
                    end
                end
            end
            ST_IDLE, ST_RUN: begin
                if (start_i) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Outputs decoded from the next state so they are registered with it.
        ready_d   = (state_d == ST_LOAD);
        cpu_rst_d = (state_d != ST_RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            ready_q   <= 1'b0;
            cpu_rst_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            ready_q   <= ready_d;
            cpu_rst_q <= cpu_rst_d;
        end
    end

    // Storage is deliberately not reset; the load count gates every read instead.
    always_ff @(posedge clk) begin
        if (xfer) begin
            mem[cnt_q[IDX_W-1:0]] <= bus.prog_data_i;
        end
    end

`ifdef INST_ROM_LOADER_CSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (state_q != ST_LOAD && start_i) begin
            csum_d = '0;
        end else if (xfer) begin
            csum_d = csum_q + bus.prog_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign csum_o = csum_q;
`else
    assign csum_o = '0;
`endif

    // Full-width compare: addresses beyond DEPTH never alias into storage.
    assign hit            = bus.rom_ce_i && (CMP_W'(cnt_q) > CMP_W'(bus.rom_addr_i));
    assign bus.rom_data_o = hit ? mem[bus.rom_addr_i[IDX_W-1:0]] : '0;

    assign bus.prog_ready_o = ready_q;
    assign cpu_rst_o        = cpu_rst_q;
    assign load_cnt_o       = cnt_q;
    assign ovf_o            = ovf_q;
endmodule

// File: tb/tb_inst_rom_loader.sv
// tb/tb_inst_rom_loader.sv - self-checking bench for inst_rom_loader (DEPTH=8)
module tb_inst_rom_loader;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int DEPTH  = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0;
    logic        cpu_rst_o;
    logic [3:0]  load_cnt_o;
    logic        ovf_o;
    logic [15:0] csum_o;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    inst_rom_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    inst_rom_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .bus        (bus),
        .cpu_rst_o  (cpu_rst_o),
        .load_cnt_o (load_cnt_o),
        .ovf_o      (ovf_o),
        .csum_o     (csum_o)
    );

    always #5 clk = ~clk;

    // Model: the list of accepted words plus three flags
    bit          m_load, m_run, m_ovf;
    int          m_cnt;
    logic [15:0] m_csum;
    logic [15:0] m_words [DEPTH];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_load = 1'b0; m_run = 1'b0; m_ovf = 1'b0; m_cnt = 0; m_csum = '0;
        end else if (m_load) begin
            if (bus.prog_valid_i) begin
                m_words[m_cnt] = bus.prog_data_i;
                m_cnt  = m_cnt + 1;
                m_csum = m_csum + bus.prog_data_i;
                if (bus.prog_last_i || m_cnt == DEPTH) begin
                    m_load = 1'b0;
                    m_run  = 1'b1;
                    if (!bus.prog_last_i) m_ovf = 1'b1;
                end
            end
        end else if (start_i) begin
            m_load = 1'b1; m_run = 1'b0; m_ovf = 1'b0; m_cnt = 0; m_csum = '0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    logic [15:0] exp_data, exp_csum;
    int          a_idx;

    always @(negedge clk) begin
        if (chk_en) begin
            a_idx    = int'(bus.rom_addr_i);
            exp_data = (bus.rom_ce_i && a_idx < m_cnt) ? m_words[a_idx] : 16'h0000;
`ifdef INST_ROM_LOADER_CSUM_EN
            exp_csum = m_csum;
`else
            exp_csum = 16'h0000;
`endif
            check("cyc_cpu_rst", 32'(cpu_rst_o), 32'(!m_run));
            check("cyc_ready", 32'(bus.prog_ready_o), 32'(m_load));
            check("cyc_cnt", 32'(load_cnt_o), 32'(m_cnt));
            check("cyc_ovf", 32'(ovf_o), 32'(m_ovf));
            check("cyc_csum", 32'(csum_o), 32'(exp_csum));
            check("cyc_data", 32'(bus.rom_data_o), 32'(exp_data));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] d, input logic last);
        bus.prog_valid_i = 1'b1;
        bus.prog_data_i  = d;
        bus.prog_last_i  = last;
        tick();
        bus.prog_valid_i = 1'b0;
        bus.prog_last_i  = 1'b0;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic rd(input string name, input logic ce, input logic [15:0] addr,
                      input logic [15:0] exp);
        bus.rom_ce_i   = ce;
        bus.rom_addr_i = addr;
        @(negedge clk);
        #1;
        check(name, 32'(bus.rom_data_o), 32'(exp));
    endtask

    initial begin
        bus.prog_valid_i = 1'b0;
        bus.prog_data_i  = '0;
        bus.prog_last_i  = 1'b0;
        bus.rom_ce_i     = 1'b1;
        bus.rom_addr_i   = '0;
        #1 rst = 1'b1;
        #1 chk_en = 1'b1;

        // Reset held for 4 cycles
        repeat (4) tick();
        check("rst_cpu_rst", 32'(cpu_rst_o), 32'd1);
        check("rst_ready", 32'(bus.prog_ready_o), 32'd0);
        check("rst_cnt", 32'(load_cnt_o), 32'd0);
        check("rst_csum", 32'(csum_o), 32'd0);
        rd("rst_rd0", 1'b1, 16'd0, 16'h0000);
        rd("rst_rd5", 1'b1, 16'd5, 16'h0000);
        @(posedge clk); #1 rst = 1'b0;
        tick();
        check("idle_ready", 32'(bus.prog_ready_o), 32'd0);

        // Basic three-word load
        pulse_start();
        check("load_ready", 32'(bus.prog_ready_o), 32'd1);
        send(16'h3443, 1'b0);
        check("load_cnt1", 32'(load_cnt_o), 32'd1);
        send(16'h0000, 1'b0);
        check("load_cpu_rst_held", 32'(cpu_rst_o), 32'd1);
        send(16'h3501, 1'b1);
        check("load_cnt3", 32'(load_cnt_o), 32'd3);
        check("load_cpu_rst_rel", 32'(cpu_rst_o), 32'd0);
        check("load_ready_off", 32'(bus.prog_ready_o), 32'd0);
        rd("load_rd0", 1'b1, 16'd0, 16'h3443);
        rd("load_rd1", 1'b1, 16'd1, 16'h0000);
        rd("load_rd2", 1'b1, 16'd2, 16'h3501);
        rd("load_rd3", 1'b1, 16'd3, 16'h0000);

        // Backpressure: valid 1,0,1
        tick();
        pulse_start();
        check("bp_cpu_rst", 32'(cpu_rst_o), 32'd1);
        check("bp_cnt0", 32'(load_cnt_o), 32'd0);
        send(16'h1111, 1'b0);
        check("bp_cnt1", 32'(load_cnt_o), 32'd1);
        bus.prog_data_i = 16'hDEAD;
        tick();
        check("bp_cnt_hold", 32'(load_cnt_o), 32'd1);
        send(16'h2222, 1'b1);
        check("bp_cnt2", 32'(load_cnt_o), 32'd2);
        rd("bp_rd0", 1'b1, 16'd0, 16'h1111);
        rd("bp_rd1", 1'b1, 16'd1, 16'h2222);
        rd("bp_rd2", 1'b1, 16'd2, 16'h0000);

        // start_i coincident with a transfer in LOAD is ignored
        tick();
        pulse_start();
        start_i = 1'b1;
        send(16'h5555, 1'b0);
        start_i = 1'b0;
        check("sim_cnt1", 32'(load_cnt_o), 32'd1);
        check("sim_ready", 32'(bus.prog_ready_o), 32'd1);
        send(16'h6666, 1'b1);
        check("sim_cnt2", 32'(load_cnt_o), 32'd2);

        // Overflow: DEPTH words without last
        tick();
        pulse_start();
        for (int i = 0; i < DEPTH; i++) send(16'h1000 + 16'(i), 1'b0);
        check("ovf_flag", 32'(ovf_o), 32'd1);
        check("ovf_cnt", 32'(load_cnt_o), 32'd8);
        check("ovf_cpu_rst", 32'(cpu_rst_o), 32'd0);
        check("ovf_ready", 32'(bus.prog_ready_o), 32'd0);
        rd("ovf_rd8", 1'b1, 16'd8, 16'h0000);
        rd("ovf_rd7", 1'b1, 16'd7, 16'h1007);
        rd("ovf_rd0", 1'b1, 16'd0, 16'h1000);
        rd("ovf_rdffff", 1'b1, 16'hFFFF, 16'h0000);
        rd("ovf_ce_off", 1'b0, 16'd0, 16'h0000);

        // Reload from RUN
        tick();
        pulse_start();
        check("rl_cpu_rst", 32'(cpu_rst_o), 32'd1);
        check("rl_cnt", 32'(load_cnt_o), 32'd0);
        check("rl_ovf", 32'(ovf_o), 32'd0);
        send(16'h3443, 1'b1);
        rd("rl_rd1", 1'b1, 16'd1, 16'h0000);
        rd("rl_rd0", 1'b1, 16'd0, 16'h3443);

        // Checksum wraps modulo 2^16
        tick();
        pulse_start();
        send(16'hFFFF, 1'b0);
        send(16'h0002, 1'b1);
`ifdef INST_ROM_LOADER_CSUM_EN
        check("csum_wrap", 32'(csum_o), 32'h0001);
`else
        check("csum_off", 32'(csum_o), 32'h0000);
`endif

        // Asynchronous reset in the middle of a load
        tick();
        pulse_start();
        send(16'hAAAA, 1'b0);
        send(16'hBBBB, 1'b0);
        rst = 1'b1;
        #1;
        check("mid_rst_cnt", 32'(load_cnt_o), 32'd0);
        check("mid_rst_cpu_rst", 32'(cpu_rst_o), 32'd1);
        check("mid_rst_ready", 32'(bus.prog_ready_o), 32'd0);
        rd("mid_rst_rd0", 1'b1, 16'd0, 16'h0000);
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) tick();
        check("post_rst_ready", 32'(bus.prog_ready_o), 32'd0);
        rd("post_rst_rd1", 1'b1, 16'd1, 16'h0000);

        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
